// File: rtl/sub_64_seq_pkg.sv
// Shared types and constants for the sequential 64-bit subtractor.
// Slice-serial: one shared slice subtractor, borrow held in a flop.
package sub_64_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int W_DEFAULT       = 64;
  localparam int SLICE_W_DEFAULT = 16;

  function automatic int slice_cnt(input int w, input int sw);
    return w / sw;
  endfunction

endpackage

// File: rtl/sub_64_seq_slice.sv
// Combinational SLICE_W-bit subtract with borrow-in and borrow-out.
// Computed as a + ~b + ~bi; the borrow is the inverted carry.
module sub_slice #(
  parameter int SLICE_W = 16
) (
  output logic [SLICE_W-1:0] d,
  output logic               bo,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bi
);

  logic [SLICE_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, ~b} + {{SLICE_W{1'b0}}, ~bi};
  assign d   = sum[SLICE_W-1:0];
  assign bo  = ~sum[SLICE_W];

endmodule

// File: rtl/sub_64_seq.sv
// Multi-cycle W-bit subtractor: a - b - b_in, one slice per clock.
// Valid/ready on both sides; no overlap between operations.
module sub_64_seq
  import sub_64_seq_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int SLICE_W = SLICE_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         b_out,
  output logic         ovf
);

  localparam int N  = slice_cnt(W, SLICE_W);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_t state_q, state_d;

  logic [KW-1:0]      k_q;
  logic               bor_q;
  logic [W-1:0]       a_q, b_q, diff_q;
  logic               b_out_q, ovf_q;
  logic [SLICE_W-1:0] a_sl, b_sl, d_sl;
  logic               bo_sl;
  logic               last;
  logic               accept;

  assign last   = (k_q == KW'(N - 1));
  assign accept = (state_q == IDLE) && in_valid;
  assign a_sl   = a_q[int'(k_q)*SLICE_W +: SLICE_W];
  assign b_sl   = b_q[int'(k_q)*SLICE_W +: SLICE_W];

  sub_slice #(.SLICE_W(SLICE_W)) u_slice (
    .d  (d_sl),
    .bo (bo_sl),
    .a  (a_sl),
    .b  (b_sl),
    .bi (bor_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q     <= '0;
      bor_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        bor_q <= b_in;
        k_q   <= '0;
      end
      if (state_q == RUN) begin
        diff_q[int'(k_q)*SLICE_W +: SLICE_W] <= d_sl;
        bor_q <= bo_sl;
        if (!last) begin
          k_q <= k_q + 1'b1;
        end else begin
          // Top slice carries the sign bit, so flags settle here.
          b_out_q <= bo_sl;
          ovf_q   <= (a_q[W-1] != b_q[W-1]) &&
                     (d_sl[SLICE_W-1] != a_q[W-1]);
        end
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub_64_seq.sv
// Self-checking bench for sub_64_seq: vector table, random ops,
// consumer stall and mid-operation reset, with a result scoreboard.
module tb_sub_64_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic        b_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        b_out;
  logic        ovf;

  sub_64_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] va,
                                 input logic [63:0] vb,
                                 input logic vbin);
    exp_t e;
    logic [64:0] r;
    r    = {1'b0, va} - {1'b0, vb} - {64'd0, vbin};
    e.d  = r[63:0];
    e.bo = r[64];
    e.ov = (va[63] != vb[63]) && (r[63] != va[63]);
    return e;
  endfunction

  // Scoreboard: compare on every output handshake.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got diff %h want no result", diff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", diff, e.d);
        chk("b_out", {63'd0, b_out}, {63'd0, e.bo});
        chk("ovf", {63'd0, ovf}, {63'd0, e.ov});
      end
    end
  end

  // Drive one operation and return cycles from accept to out_valid.
  task automatic accept(input logic [63:0] va, input logic [63:0] vb,
                        input logic vbin, input exp_t e,
                        output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end
    a        = va;
    b        = vb;
    b_in     = vbin;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    b_in     = 1'($urandom);
    lat      = -1;
    for (int c = 1; c <= 10; c++) begin
      if (lat < 0) begin
        @(posedge clk);
        #1;
        if (out_valid) lat = c;
      end
    end
  endtask

  task automatic finish_op();
    @(posedge clk);
    #1;
    chk("in_ready_after", {63'd0, in_ready}, 64'd1);
    chk("out_valid_after", {63'd0, out_valid}, 64'd0);
  endtask

  vec_t vecs[8];
  int   lat;
  exp_t e;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0};
    vecs[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    vecs[3] = '{64'h0000_0001_0000_0000, 64'd0, 1'b1,
                64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};
    vecs[4] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'h8000_0000_0000_0000, 1'b1, 1'b1};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{64'd7, 64'd7, 1'b0, 64'd0, 1'b0, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    b_in      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_diff", diff, 64'd0);
    chk("rst_b_out", {63'd0, b_out}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      e = '{vecs[i].d, vecs[i].bo, vecs[i].ov};
      accept(vecs[i].a, vecs[i].b, vecs[i].bin, e, lat);
      chk("latency", 64'(lat), 64'd4);
      finish_op();
    end

    for (int i = 0; i < 6; i++) begin
      logic [63:0] ra, rb;
      logic        rc;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      accept(ra, rb, rc, model(ra, rb, rc), lat);
      chk("latency_rand", 64'(lat), 64'd4);
      finish_op();
    end

    // Consumer stall with ignored in_valid pulses.
    out_ready = 1'b0;
    accept(64'd10, 64'd3, 1'b1, '{64'd6, 1'b0, 1'b0}, lat);
    chk("latency_stall", 64'(lat), 64'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a        = {$urandom, $urandom};
      b        = {$urandom, $urandom};
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("stall_diff", diff, 64'd6);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    finish_op();
    @(posedge clk);
    #1;
    chk("stall_no_accept", {63'd0, in_ready}, 64'd1);

    // Reset during the second RUN cycle aborts the operation.
    a        = 64'd100;
    b        = 64'd1;
    b_in     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(model(64'd100, 64'd1, 1'b0));
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    sb.delete();
    #1;
    reset = 1'b0;
    chk("abort_diff", diff, 64'd0);
    chk("abort_b_out", {63'd0, b_out}, 64'd0);
    chk("abort_ovf", {63'd0, ovf}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    end
    accept(64'd7, 64'd7, 1'b0, '{64'd0, 1'b0, 1'b0}, lat);
    chk("latency_post_abort", 64'(lat), 64'd4);
    finish_op();

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
